md_unit: RTL
============

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  E-stage md instruction valid this cycle.
REQ-006 SHALL have port md_op  input  4  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo; others no-op.
REQ-007 SHALL have port rs_E  input  32  forwarded rs operand.
REQ-008 SHALL have port rt_E  input  32  forwarded rt operand.
REQ-009 SHALL have port flush  input  1  exception/interrupt taken this cycle; cancels the E-stage md instruction.
REQ-010 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-011 SHALL have port md_out  output  32  HI for mfhi, LO for mflo, else 0; this is the E-stage forwarding source mdOut_E.

Function
REQ-012 SHALL implement FSM states IDLE and BUSY with a down-counter cnt, width ceil(log2(DIV_CYCLES+1)).
REQ-013 In IDLE with start=1, flush=0, md_op in 0..3: SHALL compute the result from rs_E/rt_E sampled that edge, enter BUSY, and load cnt=MULT_CYCLES or DIV_CYCLES.
REQ-014 busy SHALL be 1 exactly while in BUSY, i.e. MULT_CYCLES or DIV_CYCLES cycles, starting the cycle after the start edge.
REQ-015 In BUSY, cnt SHALL decrement each cycle; on the edge where cnt=1, HI/LO SHALL be written with the result and the FSM SHALL return to IDLE.
REQ-016 mult/multu SHALL produce {HI,LO} = the 64-bit signed/unsigned product.
REQ-017 div/divu SHALL produce LO = quotient truncated toward zero and HI = remainder with the sign of the dividend (signed/unsigned respectively).
REQ-018 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0.
REQ-019 Divide by zero SHALL still occupy DIV_CYCLES busy cycles and SHALL leave HI/LO unchanged.
REQ-020 mthi/mtlo with start=1, flush=0 in IDLE SHALL write rs_E to HI/LO at that edge, with zero busy cycles.
REQ-021 md_out SHALL be combinational from md_op, start and the current HI/LO, with no dependence on busy.
REQ-022 start with flush=1 SHALL have no effect: no state change, no HI/LO write.
REQ-023 flush SHALL NOT cancel an operation already in BUSY; that operation completes and commits.
REQ-024 start for md_op 0..5 while in BUSY SHALL be ignored; the pipeline stall (busy|start with an md op in D) guarantees this does not occur.
REQ-025 On the completion edge (cnt=1), a new start SHALL NOT be accepted; it is accepted on the following IDLE cycle.

Reset
REQ-026 reset=0 SHALL asynchronously force state=IDLE, cnt=0, HI=0, LO=0, busy=0 and pending result=0.
REQ-027 reset asserted mid-operation SHALL discard the in-flight result without writing HI/LO.
REQ-028 Deasserting reset SHALL take effect at the next clk edge, with no extra wait cycles.

Structure
REQ-029 Package md_pkg SHALL hold the md_op encodings, the FSM state encoding and the default MULT_CYCLES/DIV_CYCLES constants; the forwarding selector decode SHALL import it.
REQ-030 The block SHALL be a single module with no sub-module; result computation is behavioral, latched at start, with cnt modelling latency.

Verification
REQ-031 Reset, then mult rs=0xFFFFFFFF rt=2 -> busy high 5 cycles; afterwards mfhi gives 0xFFFFFFFF and mflo gives 0xFFFFFFFE.
REQ-032 multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
REQ-033 div rs=-7 (0xFFFFFFF9) rt=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; then divu 7/0 -> busy 10 cycles, HI/LO unchanged.
REQ-034 mthi 0x12345678 with flush=1 -> HI unchanged; same op with flush=0 -> HI=0x12345678 next cycle, busy never asserted.
REQ-035 Start div, pull reset low at busy cycle 4 -> busy=0, HI=LO=0 immediately; start mult at the cycle cnt=1 -> ignored, accepted on the next cycle.

Source files
------------

// File: rtl/md_pkg.sv
// ----------------------------------------------------------------------------
// md_pkg
// Shared definitions for the multiply/divide unit: md_op encodings, FSM state
// encoding, default latencies and the long-operation decode helper.
// ----------------------------------------------------------------------------
package md_pkg;

    // Default busy latencies (cycles).
    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    // md_op encodings.
    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MFHI  = 4'd6;
    localparam logic [3:0] OP_MFLO  = 4'd7;

    // FSM state encoding.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // True for the operations that occupy the unit for several cycles.
    function automatic logic is_long_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_unit.sv
// ----------------------------------------------------------------------------
// md_unit
// MIPS-style HI/LO multiply/divide unit. A mult/div is computed behaviourally
// from the operands present on the accepting edge and held in a pending
// result register; a down-counter then models the latency, and HI/LO are
// written on the last busy edge. mthi/mtlo write immediately.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   asynchronous, active-low reset
//   start     in   E-stage md instruction valid
//   md_op     in   operation (see md_pkg)
//   rs_E      in   forwarded rs operand
//   rt_E      in   forwarded rt operand
//   flush     in   cancels the E-stage md instruction this cycle
//   busy      out  multi-cycle operation in progress
//   md_out    out  HI for mfhi, LO for mflo, else 0 (E-stage forwarding source)
//   dbg_state out  current FSM state (0 IDLE, 1 BUSY)
//
// Handshake: an instruction is taken on a rising edge when start=1, flush=0
// and the FSM is IDLE; start is ignored in every other cycle, including the
// completion edge. busy is high for exactly the latency, starting the cycle
// after the accepting edge.
// ----------------------------------------------------------------------------
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] md_out,
    output logic        dbg_state
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      res_hi_q, res_hi_d;
    logic [31:0]      res_lo_q, res_lo_d;
    logic             res_we_q, res_we_d;

    logic        accept;
    logic [63:0] ext_a, ext_b, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, uq, ur, quo, rem;

    assign accept = (state_q == ST_IDLE) && start && !flush;

    // Sign-extending for mult lets one 64-bit unsigned multiply give the
    // correct low 64 bits for both signed and unsigned products.
    always_comb begin
        ext_a = {32'b0, rs_E};
        ext_b = {32'b0, rt_E};
        if (md_op == OP_MULT) begin
            ext_a = {{32{rs_E[31]}}, rs_E};
            ext_b = {{32{rt_E[31]}}, rt_E};
        end
        prod = ext_a * ext_b;
    end

    // Signed divide through magnitudes: quotient takes the xor of the signs,
    // remainder the dividend's sign. 0x80000000 / -1 falls out naturally as
    // 0x80000000 rem 0.
    always_comb begin
        a_neg = (md_op == OP_DIV) && rs_E[31];
        b_neg = (md_op == OP_DIV) && rt_E[31];
        a_mag = a_neg ? (32'd0 - rs_E) : rs_E;
        b_mag = b_neg ? (32'd0 - rt_E) : rt_E;
        uq    = '0;
        ur    = '0;
        if (b_mag != 32'd0) begin
            uq = a_mag / b_mag;
            ur = a_mag % b_mag;
        end
        quo = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        rem = a_neg ? (32'd0 - ur) : ur;
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_we_d = res_we_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_long_op(md_op)) begin
                        state_d = ST_BUSY;
                        if ((md_op == OP_MULT) || (md_op == OP_MULTU)) begin
                            cnt_d    = MULT_LOAD;
                            res_hi_d = prod[63:32];
                            res_lo_d = prod[31:0];
                            res_we_d = 1'b1;
                        end else begin
                            cnt_d    = DIV_LOAD;
                            res_hi_d = rem;
                            res_lo_d = quo;
                            // Divide by zero still takes the full latency
                            // but must leave HI/LO untouched.
                            res_we_d = (rt_E != 32'd0);
                        end
                    end else if (md_op == OP_MTHI) begin
                        hi_d = rs_E;
                    end else if (md_op == OP_MTLO) begin
                        lo_d = rs_E;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d  = ST_IDLE;
                    res_we_d = 1'b0;
                    if (res_we_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            res_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_we_q <= res_we_d;
        end
    end

    assign busy      = (state_q == ST_BUSY);
    assign dbg_state = state_q;

    // Forwarding source: intentionally independent of busy.
    always_comb begin
        md_out = '0;
        if (start) begin
            if (md_op == OP_MFHI)      md_out = hi_q;
            else if (md_op == OP_MFLO) md_out = lo_q;
        end
    end

endmodule
